// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32 widths and register-index types
package rv32_pkg;

  localparam int XLEN      = 32;
  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = $clog2(NUM_REGS);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      xlen_t;

endpackage

// File: rtl/reg_file_if.sv
// rtl/reg_file_if.sv - read/write port bundle between decode/writeback and the register file
interface reg_file_if;
  import rv32_pkg::*;

  logic     Write_Enable;
  reg_idx_t rs1;
  reg_idx_t rs2;
  reg_idx_t rd;
  xlen_t    Write_Data;
  xlen_t    Rd1;
  xlen_t    Rd2;

  modport master (
    output Write_Enable, rs1, rs2, rd, Write_Data,
    input  Rd1, Rd2
  );

  modport slave (
    input  Write_Enable, rs1, rs2, rd, Write_Data,
    output Rd1, Rd2
  );

endinterface

// File: rtl/regfile_read_mux.sv
// rtl/regfile_read_mux.sv - 32:1 XLEN-wide combinational read selector
module regfile_read_mux
  import rv32_pkg::*;
(
  input  xlen_t    regs [NUM_REGS],
  input  reg_idx_t sel,
  output xlen_t    data
);

  // Index 0 is forced to zero here as well, so x0 never depends on storage.
  always_comb begin
    data = '0;
    if (sel != '0) begin
      data = regs[sel];
    end
  end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - RV32I integer register file, two combinational reads, one synchronous write
module reg_file
  import rv32_pkg::*;
(
  input logic       Clk,
  input logic       Rst,
  reg_file_if.slave bus
);

  xlen_t               regs [NUM_REGS];
  logic [NUM_REGS-1:0] load_en;

  // One-hot decode of rd gated by Write_Enable; x0 never gets a load enable.
  always_comb begin
    load_en = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      load_en[i] = bus.Write_Enable && (i != 0) && (bus.rd == reg_idx_t'(i));
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (load_en[i]) begin
          regs[i] <= bus.Write_Data;
        end
      end
    end
  end

  regfile_read_mux u_read_mux_1 (
    .regs (regs),
    .sel  (bus.rs1),
    .data (bus.Rd1)
  );

  regfile_read_mux u_read_mux_2 (
    .regs (regs),
    .sel  (bus.rs2),
    .data (bus.Rd2)
  );

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - self-checking bench for reg_file
module tb_reg_file;
  import rv32_pkg::*;

  typedef struct {
    logic     we;
    reg_idx_t rd;
    xlen_t    wdata;
    reg_idx_t rs1;
    reg_idx_t rs2;
    xlen_t    exp1;
    xlen_t    exp2;
  } vec_t;

  typedef struct {
    reg_idx_t rs1;
    reg_idx_t rs2;
    xlen_t    exp1;
    xlen_t    exp2;
  } sb_entry_t;

  logic Clk = 1'b0;
  logic Rst = 1'b0;

  reg_file_if bus ();

  reg_file dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  int        checks = 0;
  int        passed = 0;
  xlen_t     model [NUM_REGS];
  sb_entry_t sb_q [$];
  vec_t      vecs [8];

  task automatic check(input string name, input xlen_t act, input xlen_t exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive read indices, queue the expectation, then compare once the ports settle.
  task automatic read_check(input reg_idx_t r1, input reg_idx_t r2,
                            input xlen_t e1, input xlen_t e2);
    sb_entry_t e;
    bus.rs1 = r1;
    bus.rs2 = r2;
    e.rs1 = r1; e.rs2 = r2; e.exp1 = e1; e.exp2 = e2;
    sb_q.push_back(e);
    #1;
    e = sb_q.pop_front();
    check($sformatf("rd1[rs1=%0d]", e.rs1), bus.Rd1, e.exp1);
    check($sformatf("rd2[rs2=%0d]", e.rs2), bus.Rd2, e.exp2);
  endtask

  task automatic do_write(input logic we, input reg_idx_t rd, input xlen_t d);
    @(negedge Clk);
    bus.Write_Enable = we;
    bus.rd           = rd;
    bus.Write_Data   = d;
    @(posedge Clk);
    #1;
    if (we && rd != '0) model[rd] = d;
    bus.Write_Enable = 1'b0;
  endtask

  initial begin
    bus.Write_Enable = 1'b0;
    bus.rs1 = '0; bus.rs2 = '0; bus.rd = '0; bus.Write_Data = '0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;

    vecs[0] = '{1'b1, 5'd5,  32'hA5A5A5A5, 5'd5,  5'd0,  32'hA5A5A5A5, 32'h0};
    vecs[1] = '{1'b1, 5'd10, 32'h5A5A5A5A, 5'd5,  5'd10, 32'hA5A5A5A5, 32'h5A5A5A5A};
    vecs[2] = '{1'b0, 5'd10, 32'h00000000, 5'd5,  5'd10, 32'hA5A5A5A5, 32'h5A5A5A5A};
    vecs[3] = '{1'b1, 5'd15, 32'h12345678, 5'd15, 5'd5,  32'h12345678, 32'hA5A5A5A5};
    vecs[4] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0};
    vecs[5] = '{1'b0, 5'd7,  32'hDEADBEEF, 5'd7,  5'd15, 32'h0,        32'h12345678};
    vecs[6] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[7] = '{1'b1, 5'd1,  32'h00000001, 5'd1,  5'd31, 32'h00000001, 32'hCAFEF00D};

    // Asynchronous reset with no clock edge in between.
    #1 Rst = 1'b1;
    #1;
    read_check(5'd0,  5'd5,  32'h0, 32'h0);
    read_check(5'd31, 5'd0,  32'h0, 32'h0);
    @(negedge Clk);
    Rst = 1'b0;
    read_check(5'd5, 5'd31, 32'h0, 32'h0);

    foreach (vecs[k]) begin
      do_write(vecs[k].we, vecs[k].rd, vecs[k].wdata);
      read_check(vecs[k].rs1, vecs[k].rs2, vecs[k].exp1, vecs[k].exp2);
    end

    for (int i = 1; i < NUM_REGS; i++) begin
      do_write(1'b1, reg_idx_t'(i), 32'h0101_0000 | xlen_t'(i));
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      read_check(reg_idx_t'(i), reg_idx_t'(NUM_REGS - 1 - i),
                 (i == 0) ? 32'h0 : (32'h0101_0000 | xlen_t'(i)),
                 (i == NUM_REGS - 1) ? 32'h0 : (32'h0101_0000 | xlen_t'(NUM_REGS - 1 - i)));
    end

    // Read-during-write: old value before the edge, new value after it.
    do_write(1'b1, 5'd3, 32'h11);
    @(negedge Clk);
    bus.Write_Enable = 1'b1;
    bus.rd           = 5'd3;
    bus.Write_Data   = 32'h22;
    read_check(5'd3, 5'd18, 32'h11, 32'h0101_0012);
    @(posedge Clk);
    #1;
    read_check(5'd3, 5'd19, 32'h22, 32'h0101_0013);

    // Reset between edges clears immediately and overrides a pending write.
    bus.Write_Data = 32'h33;
    #1 Rst = 1'b1;
    read_check(5'd3, 5'd31, 32'h0, 32'h0);
    @(posedge Clk);
    #1;
    read_check(5'd3, 5'd5, 32'h0, 32'h0);
    @(negedge Clk);
    Rst = 1'b0;
    bus.Write_Enable = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    @(posedge Clk);
    #1;
    read_check(5'd3, 5'd10, model[3], model[10]);

    do_write(1'b1, 5'd3, 32'h44);
    read_check(5'd3, 5'd4, model[3], model[4]);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
